izh_scheduler: RTL

IZH_SCHEDULER -- requirements
Module: izh_scheduler

---
 rtl/izh_pkg.sv | 19 +
 rtl/izh_spike_fifo.sv | 61 ++++++
 rtl/izh_scheduler.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/izh_pkg.sv
// Shared types and defaults for the time-multiplexed Izhikevich neuron scheduler.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package izh_pkg;

    // Sweep controller states: IDLE waits for tick, ISSUE/WAIT/WRITE walk one neuron.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam int          N_NEURONS_DEF  = 4;
    localparam int          FIFO_DEPTH_DEF = 4;
    localparam logic [7:0]  V_INIT_DEF     = 8'hBF;  // -65
    localparam logic [7:0]  U_INIT_DEF     = 8'hF3;  // -13

endpackage

// File: rtl/izh_spike_fifo.sv
// Spike-event FIFO holding neuron ids in arrival order.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module izh_spike_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] data
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign data    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign do_push = push && (!full || do_pop);

    // Storage array: written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/izh_scheduler.sv
// Sweeps N virtual Izhikevich neurons through one shared update datapath per tick.
// Latency: tick -> dp_start next cycle; each neuron costs 2 cycles plus datapath latency.
// Backpressure: waits indefinitely for dp_done; spikes are dropped (sticky flag) when the FIFO is full.
module izh_scheduler
    import izh_pkg::*;
#(
    parameter int         N_NEURONS  = N_NEURONS_DEF,
    parameter int         FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter logic [7:0] V_INIT     = V_INIT_DEF,
    parameter logic [7:0] U_INIT     = U_INIT_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic                         cfg_we,
    input  logic [$clog2(N_NEURONS)-1:0] cfg_sel,
    input  logic [7:0]                   cfg_cur,
    output logic                         dp_start,
    output logic [7:0]                   dp_v,
    output logic [7:0]                   dp_u,
    output logic [7:0]                   dp_i,
    input  logic                         dp_done,
    input  logic [7:0]                   dp_v_next,
    input  logic [7:0]                   dp_u_next,
    input  logic                         dp_spike,
    output logic                         spk_valid,
    output logic [$clog2(N_NEURONS)-1:0] spk_id,
    input  logic                         spk_ready,
    output logic                         busy,
    output logic [7:0]                   v_mon,
    output logic                         overrun,
    output logic                         spk_drop
);
    localparam int IW = $clog2(N_NEURONS);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] idx;
    logic [IW-1:0] ld_idx;
    logic          load_ops;
    logic          last;

    logic [7:0]    v_mem   [N_NEURONS];
    logic [7:0]    u_mem   [N_NEURONS];
    logic [7:0]    cur_mem [N_NEURONS];

    logic [7:0]    res_v;
    logic [7:0]    res_u;
    logic          res_spk;

    logic          spk_push;
    logic          spk_pop;
    logic          fifo_full;
    logic          fifo_empty;

    assign last      = (idx == IW'(N_NEURONS - 1));
    assign busy      = (state != ST_IDLE);
    assign dp_start  = (state == ST_ISSUE);
    assign v_mon     = v_mem[cfg_sel];
    assign spk_push  = (state == ST_WRITE) && res_spk;
    assign spk_valid = !fifo_empty;
    assign spk_pop   = spk_valid && spk_ready;

    // Next-state decode; load_ops marks the edge that enters ISSUE so operands are valid during it.
    always_comb begin
        state_nxt = state;
        load_ops  = 1'b0;
        ld_idx    = idx;
        case (state)
            ST_IDLE: begin
                if (tick) begin
                    state_nxt = ST_ISSUE;
                    load_ops  = 1'b1;
                    ld_idx    = '0;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (dp_done) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (last) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_ISSUE;
                    load_ops  = 1'b1;
                    ld_idx    = idx + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Neuron index and operand registers; a same-cycle current write for the neuron being loaded is forwarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= '0;
            dp_v <= '0;
            dp_u <= '0;
            dp_i <= '0;
        end else if (load_ops) begin
            idx  <= ld_idx;
            dp_v <= v_mem[ld_idx];
            dp_u <= u_mem[ld_idx];
            dp_i <= (cfg_we && (cfg_sel == ld_idx)) ? cfg_cur : cur_mem[ld_idx];
        end
    end

    // Capture the datapath result when it is presented, so WRITE does not depend on the datapath holding it.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_v   <= '0;
            res_u   <= '0;
            res_spk <= 1'b0;
        end else if ((state == ST_WAIT) && dp_done) begin
            res_v   <= dp_v_next;
            res_u   <= dp_u_next;
            res_spk <= dp_spike;
        end
    end

    // Membrane/recovery state array, updated bit-exact in WRITE.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < N_NEURONS; n++) begin
                v_mem[n] <= V_INIT;
                u_mem[n] <= U_INIT;
            end
        end else if (state == ST_WRITE) begin
            v_mem[idx] <= res_v;
            u_mem[idx] <= res_u;
        end
    end

    // Input current registers, writable in any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < N_NEURONS; n++) begin
                cur_mem[n] <= '0;
            end
        end else if (cfg_we) begin
            cur_mem[cfg_sel] <= cfg_cur;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun  <= 1'b0;
            spk_drop <= 1'b0;
        end else begin
            if (tick && busy) begin
                overrun <= 1'b1;
            end
            if (spk_push && fifo_full && !spk_pop) begin
                spk_drop <= 1'b1;
            end
        end
    end

    izh_spike_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (IW)
    ) u_spike_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (spk_push),
        .din   (idx),
        .pop   (spk_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .data  (spk_id)
    );

endmodule
